// File: rtl/decrypted_msg_checker.sv
// Snapshots a decrypted candidate message, streams it byte-by-byte into the message RAM,
// and classifies it as plausible plaintext (lowercase a-z or space only).
module decrypted_msg_checker #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] decrypted_data [MSG_LEN-1:0],
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              msg_valid,
  output logic [ADDR_W-1:0] first_bad_addr
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MSG_LEN - 1);

  state_e            state_q, state_d;
  logic              start_q;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] snap_q [MSG_LEN-1:0];
  logic [DATA_W-1:0] snap_d [MSG_LEN-1:0];
  logic              bad_seen_q, bad_seen_d;
  logic [ADDR_W-1:0] bad_idx_q, bad_idx_d;
  logic              msg_valid_q, msg_valid_d;
  logic [ADDR_W-1:0] first_bad_q, first_bad_d;

  logic              launch;
  logic [DATA_W-1:0] cur_byte;
  logic              cur_bad;

  assign launch   = start & ~start_q;
  assign cur_byte = snap_q[idx_q];
  assign cur_bad  = !((cur_byte == DATA_W'(8'h20)) ||
                      ((cur_byte >= DATA_W'(8'h61)) && (cur_byte <= DATA_W'(8'h7A))));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    bad_seen_d  = bad_seen_q;
    bad_idx_d   = bad_idx_q;
    msg_valid_d = msg_valid_q;
    first_bad_d = first_bad_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          snap_d     = decrypted_data;
          idx_d      = '0;
          bad_seen_d = 1'b0;
          bad_idx_d  = '0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (cur_bad && !bad_seen_q) begin
          bad_seen_d = 1'b1;
          bad_idx_d  = idx_q;
        end
        if (idx_q == LastIdx) begin
          // Verdict folds in the last byte, which has not reached bad_seen_q yet.
          state_d     = StDone;
          msg_valid_d = !(bad_seen_q || cur_bad);
          if (bad_seen_q)   first_bad_d = bad_idx_q;
          else if (cur_bad) first_bad_d = idx_q;
          else              first_bad_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      idx_q       <= '0;
      snap_q      <= '{default: '0};
      bad_seen_q  <= 1'b0;
      bad_idx_q   <= '0;
      msg_valid_q <= 1'b0;
      first_bad_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      bad_seen_q  <= bad_seen_d;
      bad_idx_q   <= bad_idx_d;
      msg_valid_q <= msg_valid_d;
      first_bad_q <= first_bad_d;
    end
  end

  always_comb begin
    ram_wren       = (state_q == StWrite);
    ram_address    = ram_wren ? idx_q : '0;
    ram_data       = ram_wren ? cur_byte : '0;
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    msg_valid      = msg_valid_q;
    first_bad_addr = first_bad_q;
  end

endmodule

// File: tb/tb_decrypted_msg_checker.sv
// Bench for decrypted_msg_checker: table vectors, random messages against a scan model,
// and hand sequences for start-edge filtering and mid-run reset.
module tb_decrypted_msg_checker;

  typedef logic [7:0] msg_t [31:0];

  typedef struct {
    logic [7:0] fill;
    int         p1;
    logic [7:0] v1;
    int         p2;
    logic [7:0] v2;
    logic       ev;
    int         eb;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  msg_t       dd;
  logic [4:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic       msg_valid;
  logic [4:0] first_bad_addr;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_valid = 1'b0;
  int   prev_bad   = 0;

  always #5 clk = ~clk;

  decrypted_msg_checker dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .decrypted_data(dd),
    .ram_address   (ram_address),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .busy          (busy),
    .done          (done),
    .msg_valid     (msg_valid),
    .first_bad_addr(first_bad_addr)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Plaintext rule: space or lowercase letter; returns lowest offending index or -1.
  function automatic int model_first_bad(input msg_t m);
    for (int i = 0; i < 32; i++) begin
      if (!(m[i] == 8'h20 || (m[i] >= 8'h61 && m[i] <= 8'h7A))) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one run; upstream data is trashed right after launch to prove the snapshot.
  task automatic run_msg(input msg_t m, input string nm, input logic ev, input int eb);
    int wr_err = 0, done_cyc = 0, n_done = 0, hold_err = 0;
    dd    = m;
    start = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0;
        for (int i = 0; i < 32; i++) dd[i] = 8'hFF;
      end
      if (c <= 32) begin
        if (!(ram_wren === 1'b1 && ram_address === 5'(c - 1) && ram_data === m[c-1] &&
              busy === 1'b1)) wr_err++;
      end else if (ram_wren !== 1'b0 || ram_address !== 5'd0 || ram_data !== 8'd0) begin
        wr_err++;
      end
      if (c == 16 && (msg_valid !== prev_valid || int'(first_bad_addr) != prev_bad)) hold_err++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == 33) begin
        check({nm, " msg_valid"}, int'(msg_valid), int'(ev));
        check({nm, " first_bad_addr"}, int'(first_bad_addr), eb);
        check({nm, " busy_in_done"}, int'(busy), 1);
      end
      if (c == 34) begin
        check({nm, " verdict_held"}, int'({msg_valid, first_bad_addr}), int'({ev, 5'(eb)}));
        check({nm, " idle_after"}, int'(busy), 0);
      end
    end
    check({nm, " writes"}, wr_err, 0);
    check({nm, " done_cycle"}, done_cyc, 33);
    check({nm, " done_count"}, n_done, 1);
    check({nm, " prev_verdict_hold"}, hold_err, 0);
    prev_valid = ev;
    prev_bad   = eb;
  endtask

  initial begin
    vec_t tbl [6];
    msg_t m;
    int   fb, n_done, n_wr;
    bit   hit;

    tbl[0] = '{fill: 8'h61, p1: 0,  v1: 8'h61, p2: 0,  v2: 8'h61, ev: 1'b1, eb: 0};
    tbl[1] = '{fill: 8'h20, p1: 5,  v1: 8'h41, p2: 5,  v2: 8'h41, ev: 1'b0, eb: 5};
    tbl[2] = '{fill: 8'h61, p1: 3,  v1: 8'h7B, p2: 20, v2: 8'h00, ev: 1'b0, eb: 3};
    tbl[3] = '{fill: 8'h20, p1: 31, v1: 8'h60, p2: 31, v2: 8'h60, ev: 1'b0, eb: 31};
    tbl[4] = '{fill: 8'h7A, p1: 0,  v1: 8'h20, p2: 31, v2: 8'h61, ev: 1'b1, eb: 0};
    tbl[5] = '{fill: 8'h62, p1: 0,  v1: 8'h00, p2: 30, v2: 8'h5F, ev: 1'b0, eb: 0};

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) dd[i] = 8'h00;
    tick();
    tick();
    check("reset outputs",
          int'({ram_address, ram_data, ram_wren, busy, done, msg_valid, first_bad_addr}), 0);
    reset = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) m[i] = tbl[t].fill;
      m[tbl[t].p1] = tbl[t].v1;
      m[tbl[t].p2] = tbl[t].v2;
      run_msg(m, $sformatf("vec%0d", t), tbl[t].ev, tbl[t].eb);
      tick();
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 99) < 97)
          m[i] = ($urandom_range(0, 26) == 26) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
        else
          m[i] = 8'($urandom_range(0, 255));
      end
      fb = model_first_bad(m);
      run_msg(m, $sformatf("rand%0d", r), fb < 0, (fb < 0) ? 0 : fb);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Level held high must launch only once.
    for (int i = 0; i < 32; i++) dd[i] = 8'h61;
    start  = 1'b1;
    n_done = 0;
    n_wr   = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      n_done += int'(done);
      n_wr   += int'(ram_wren);
    end
    start = 1'b0;
    check("held_start dones", n_done, 1);
    check("held_start writes", n_wr, 32);
    prev_valid = 1'b1;
    prev_bad   = 0;

    // Fresh edge during WRITE is discarded.
    tick();
    start  = 1'b1;
    n_done = 0;
    n_wr   = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      n_done += int'(done);
      n_wr   += int'(ram_wren);
    end
    check("pulse_in_write dones", n_done, 1);
    check("pulse_in_write writes", n_wr, 32);

    // Reset mid-run at idx 10 aborts immediately.
    start = 1'b1;
    hit   = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      start = 1'b0;
      if (ram_wren === 1'b1 && ram_address === 5'd10) hit = 1'b1;
    end
    check("reach idx10", int'(hit), 1);
    reset = 1'b1;
    #1;
    check("midrun_reset wren", int'(ram_wren), 0);
    check("midrun_reset state",
          int'({busy, done, msg_valid, first_bad_addr, ram_address, ram_data}), 0);
    tick();
    tick();
    reset  = 1'b0;
    n_done = 0;
    n_wr   = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n_done += int'(done);
      n_wr   += int'(ram_wren);
    end
    check("after_reset no done", n_done, 0);
    check("after_reset no writes", n_wr, 0);
    check("after_reset msg_valid", int'(msg_valid), 0);
    prev_valid = 1'b0;
    prev_bad   = 0;
    for (int i = 0; i < 32; i++) m[i] = (i % 3 == 0) ? 8'h20 : 8'h71;
    run_msg(m, "post_reset", 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
